// File: rtl/floating_to_int.sv
// floating_to_int
//   Multi-cycle IEEE-754 single-precision to 32-bit signed integer converter.
//   Rounds toward zero and saturates out-of-range values. NaN returns
//   NAN_RESULT. The magnitude is aligned with a shifter that moves one bit per
//   cycle, which keeps the datapath small.
//
// Ports
//   clk        clock; all logic on posedge
//   rst_n      synchronous active-low reset
//   in_valid   in_float is valid
//   in_ready   converter is idle and can accept an operand
//   in_float   operand {sign[31], exponent[30:23], mantissa[22:0]}
//   out_valid  out_int / out_flags are valid (held until out_ready)
//   out_ready  consumer accepts the result
//   out_int    signed integer result
//   out_flags  {invalid, overflow, inexact}
module floating_to_int #(
  parameter logic [31:0] NAN_RESULT = 32'h80000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_float,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_int,
  output logic [2:0]  out_flags
);

  typedef enum logic [2:0] {
    IDLE,
    CLASSIFY,
    SHIFT,
    NEGATE,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] op_q, op_d;
  logic [31:0] data_q, data_d;
  logic [2:0]  flags_q, flags_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        left_q, left_d;

  logic        sign_w;
  logic [7:0]  exp_w;
  logic [22:0] mant_w;
  logic [31:0] sat_w;
  logic [7:0]  dist_w;

  assign sign_w = op_q[31];
  assign exp_w  = op_q[30:23];
  assign mant_w = op_q[22:0];
  assign sat_w  = sign_w ? 32'h80000000 : 32'h7FFFFFFF;
  // The significand starts aligned so that bit 23 has weight 2^23 (e = 150);
  // the shift distance is the exponent's distance from that point.
  assign dist_w = (exp_w >= 8'd150) ? (exp_w - 8'd150) : (8'd150 - exp_w);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    flags_d = flags_q;
    cnt_d   = cnt_q;
    left_d  = left_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d    = in_float;
          state_d = CLASSIFY;
        end
      end
      CLASSIFY: begin
        flags_d = '0;
        cnt_d   = '0;
        left_d  = 1'b0;
        state_d = DONE;
        if (exp_w == 8'd255 && mant_w != '0) begin
          data_d  = NAN_RESULT;
          flags_d = 3'b100;
        end else if (exp_w == 8'd255) begin
          data_d  = sat_w;
          flags_d = 3'b010;
        end else if (exp_w == 8'd158 && sign_w && mant_w == '0) begin
          data_d  = 32'h80000000;
        end else if (exp_w >= 8'd158) begin
          data_d  = sat_w;
          flags_d = 3'b010;
        end else if (exp_w < 8'd127) begin
          data_d     = '0;
          flags_d[0] = (exp_w != '0) || (mant_w != '0);
        end else begin
          data_d  = {8'd0, 1'b1, mant_w};
          left_d  = (exp_w >= 8'd150);
          cnt_d   = dist_w[4:0];
          state_d = (dist_w == '0) ? NEGATE : SHIFT;
        end
      end
      SHIFT: begin
        if (left_q) begin
          data_d = {data_q[30:0], 1'b0};
        end else begin
          data_d     = {1'b0, data_q[31:1]};
          flags_d[0] = flags_q[0] | data_q[0];
        end
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = NEGATE;
        end
      end
      NEGATE: begin
        if (sign_w) begin
          data_d = ~data_q + 32'd1;
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      data_q  <= '0;
      flags_q <= '0;
      cnt_q   <= '0;
      left_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_int   = data_q;
  assign out_flags = flags_q;

endmodule

// File: tb/tb_floating_to_int.sv
// Bench for floating_to_int: reset behaviour, a vector table of conversions
// with expected result / flags / latency, backpressure hold and abort by reset.
module tb_floating_to_int;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_float = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_int;
  logic [2:0]  out_flags;

  floating_to_int #(.NAN_RESULT(32'h80000000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_float  (in_float),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_int   (out_int),
    .out_flags (out_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] fin;
    logic [31:0] res;
    logic [2:0]  flg;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  flg;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  // Drives one operand, measures latency, compares via the scoreboard, then
  // optionally withholds out_ready for 'hold' cycles before accepting.
  task automatic run_vec(input logic [31:0] fin, input logic [31:0] res,
                         input logic [2:0] flg, input int lat, input int hold);
    exp_t e;
    int   n;
    @(negedge clk);
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_float = fin;
    @(posedge clk);
    e.res = res; e.flg = flg; e.lat = lat;
    sb.push_back(e);
    n = 1;
    #1 in_valid = 1'b0;
    @(negedge clk);
    while (!out_valid && n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("out_valid_seen", {31'd0, out_valid}, 32'd1);
    e = sb.pop_front();
    check($sformatf("out_int[%h]", fin), out_int, e.res);
    check($sformatf("out_flags[%h]", fin), {29'd0, out_flags}, {29'd0, e.flg});
    check($sformatf("latency[%h]", fin), n, e.lat);
    check("in_ready_busy", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_int", out_int, e.res);
      check("hold_flags", {29'd0, out_flags}, {29'd0, e.flg});
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("released_valid", {31'd0, out_valid}, 32'd0);
    check("released_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  vec_t vecs[16];
  int   seen;

  initial begin
    vecs[0]  = '{32'h3F800000, 32'h00000001, 3'b000, 26};
    vecs[1]  = '{32'h4B000000, 32'h00800000, 3'b000, 3};
    vecs[2]  = '{32'h4EFFFFFF, 32'h7FFFFF80, 3'b000, 10};
    vecs[3]  = '{32'hBFC00000, 32'hFFFFFFFF, 3'b001, 26};
    vecs[4]  = '{32'h3F000000, 32'h00000000, 3'b001, 2};
    vecs[5]  = '{32'h80000000, 32'h00000000, 3'b000, 2};
    vecs[6]  = '{32'h4F000000, 32'h7FFFFFFF, 3'b010, 2};
    vecs[7]  = '{32'hCF000000, 32'h80000000, 3'b000, 2};
    vecs[8]  = '{32'hFF800000, 32'h80000000, 3'b010, 2};
    vecs[9]  = '{32'h7FC00000, 32'h80000000, 3'b100, 2};
    vecs[10] = '{32'h40400000, 32'h00000003, 3'b000, 25};
    vecs[11] = '{32'hC2F60000, 32'hFFFFFF85, 3'b000, 20};
    vecs[12] = '{32'h7F800000, 32'h7FFFFFFF, 3'b010, 2};
    vecs[13] = '{32'h00000001, 32'h00000000, 3'b001, 2};
    vecs[14] = '{32'h3FFFFFFF, 32'h00000001, 3'b001, 26};
    vecs[15] = '{32'h5F000000, 32'h7FFFFFFF, 3'b010, 2};

    // Reset held with in_valid asserted: nothing may be captured.
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_float = 32'h3F800000;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_int", out_int, 32'd0);
      check("rst_out_flags", {29'd0, out_flags}, 32'd0);
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);

    for (int i = 0; i < 16; i++) begin
      run_vec(vecs[i].fin, vecs[i].res, vecs[i].flg, vecs[i].lat, 0);
    end

    // Backpressure: hold the result for 5 cycles, then a follow-on operand.
    run_vec(32'hC2F60000, 32'hFFFFFF85, 3'b000, 20, 5);
    run_vec(32'h3F800000, 32'h00000001, 3'b000, 26, 0);

    // Abort: reset while shifting 1.0, no result may appear afterwards.
    @(negedge clk);
    in_valid = 1'b1;
    in_float = 32'h3F800000;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("abort_no_result", seen, 0);
    run_vec(32'h40400000, 32'h00000003, 3'b000, 25, 0);

    check("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual running required finished");
    $fatal(1, "timeout");
  end

endmodule
